// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder slice: nibble width and FSM state encoding.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder; master drives operands, slave returns results.
interface nibble_serial_adder_if #(
  parameter int NUM_NIBBLES = 4
);
  localparam int W = 4 * NUM_NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/adder_4bit.sv
// Single 4-bit ripple adder with carry in/out; the one arithmetic resource the serial adder reuses.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder pushing one nibble per clock through a shared adder_4bit.
// Optional signed overflow flag: define NIBBLE_SERIAL_SIGNED_OVF_EN.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W  = NIBBLE_W * NUM_NIBBLES;
  localparam int RW = W - NIBBLE_W;
  localparam int CW = $clog2(NUM_NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NUM_NIBBLES - 1);

  serial_add_state_t state;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              carry_q;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     res_q;
  logic              busy_q;
  logic              done_q;
  logic [W-1:0]      sum_q;
  logic              cout_q;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  adder_4bit u_adder (
    .a    (op_a[NIBBLE_W-1:0]),
    .b    (op_b[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
  logic ovf_q;
  logic ovf_next;

  // In the last RUN cycle the low operand nibbles are the top nibbles, so bit 3 is the MSB.
  assign ovf_next = (op_a[NIBBLE_W-1] == op_b[NIBBLE_W-1]) &&
                    (nib_sum[NIBBLE_W-1] != op_a[NIBBLE_W-1]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && cnt == LAST) begin
      ovf_q <= ovf_next;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  // The result register holds only the lower N-1 nibbles; the final nibble joins on the DONE edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a    <= bus.a;
            op_b    <= bus.b;
            carry_q <= bus.carry_in;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          op_a    <= op_a >> NIBBLE_W;
          op_b    <= op_b >> NIBBLE_W;
          carry_q <= nib_cout;
          res_q   <= RW'({nib_sum, res_q} >> NIBBLE_W);
          if (cnt == LAST) begin
            sum_q  <= {nib_sum, res_q};
            cout_q <= nib_cout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt    <= cnt + 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NUM_NIBBLES=4); honours NIBBLE_SERIAL_SIGNED_OVF_EN.
module tb_nibble_serial_adder;

  localparam int N = 4;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NUM_NIBBLES(N)) bus ();

  nibble_serial_adder #(.NUM_NIBBLES(N)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    exp_t e;
    t   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    e.s = t[15:0];
    e.c = t[16];
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    e.o = (a[15] == b[15]) && (t[15] != a[15]);
`else
    e.o = 1'b0;
`endif
    return e;
  endfunction

  // Result monitor: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (prev_done) check("done_pulse_width", {31'b0, bus.done}, 32'd0);
    if (bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", {16'b0, bus.sum}, {16'b0, e.s});
        check("carry_out", {31'b0, bus.carry_out}, {31'b0, e.c});
        check("overflow", {31'b0, bus.overflow}, {31'b0, e.o});
      end
    end
    prev_done = bus.done;
  end

  // Drives start for one edge, then scrambles the operands to prove they are not re-sampled.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.start    = 1'b1;
    sb.push_back(model(a, b, cin));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.carry_in = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      lat++;
      @(negedge clk);
    end
    if (!bus.done) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      check({tag, "_latency"}, lat, N);
      check({tag, "_busy_cycles"}, busy_n, N);
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    int gap;
    n_rst        = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
    #2 n_rst = 1'b0;
    #20;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_sum", {16'b0, bus.sum}, 32'd0);
    check("rst_cout", {31'b0, bus.carry_out}, 32'd0);
    check("rst_ovf", {31'b0, bus.overflow}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    launch(16'h00FF, 16'h0001, 1'b0);
    wait_done("t1");
    launch(16'hFFFF, 16'h0000, 1'b1);
    wait_done("t2");
    launch(16'h7FFF, 16'h0001, 1'b0);
    wait_done("t3");
    launch(16'h8000, 16'h8000, 1'b0);
    wait_done("t3b");

    // start during RUN must be ignored
    base = done_cnt;
    launch(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    gap = 0;
    while (!bus.done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    repeat (10) @(negedge clk);
    check("ignored_start_results", done_cnt - base, 32'd1);

    // reset in the third RUN cycle
    base = done_cnt;
    launch(16'hAAAA, 16'h5555, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_busy", {31'b0, bus.busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_sum", {16'b0, bus.sum}, 32'd0);
    check("abort_cout", {31'b0, bus.carry_out}, 32'd0);
    check("abort_ovf", {31'b0, bus.overflow}, 32'd0);
    sb.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - base, 32'd0);
    launch(16'h0003, 16'h0004, 1'b0);
    wait_done("t5");

    // back-to-back: start held through DONE
    @(negedge clk);
    bus.a        = 16'h0F0F;
    bus.b        = 16'h0101;
    bus.carry_in = 1'b0;
    bus.start    = 1'b1;
    sb.push_back(model(16'h0F0F, 16'h0101, 1'b0));
    gap = 0;
    while (!bus.done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_first_done", {31'b0, bus.done}, 32'd1);
    bus.a = 16'h0010;
    bus.b = 16'h0020;
    sb.push_back(model(16'h0010, 16'h0020, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    while (!bus.done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, 32'd5);
    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
